dsp_mac_slice_mc: RTL and testbench

- Parametrised successor to the single-channel DSP48A1-style slice: pre-adder, signed multiplier and post-adder/accumulator.
- Adds a fixed 3-stage valid pipeline, NCH time-multiplexed per-channel accumulators, optional saturation, and pattern detect.
- Sits in the datapath wherever several independent filter/MAC streams share one multiplier.

---
 rtl/dsp_mac_slice_mc.sv | 203 ++++++++++++++++++++
 tb/tb_dsp_mac_slice_mc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_slice_mc.sv
// Three-stage pre-add / multiply / post-add MAC slice with NCH time-multiplexed
// accumulators, optional saturation and pattern detect.
module dsp_mac_slice_mc #(
  parameter int            AW         = 18,
  parameter int            BW         = 18,
  parameter int            CW         = 48,
  parameter int            PW         = 48,
  parameter int            NCH        = 4,
  parameter bit            SATURATE   = 1'b0,
  parameter                CARRYINSEL = "OPMODE5",
  parameter logic [PW-1:0] PATTERN    = '0,
  parameter logic [PW-1:0] MASK       = '0,
  localparam int           CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [CHW-1:0]       ch,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [AW-1:0] d,
  input  logic signed [CW-1:0] c,
  input  logic                 carryin,
  input  logic [7:0]           opmode,
  input  logic signed [PW-1:0] pcin,
  output logic                 out_valid,
  output logic [CHW-1:0]       ch_out,
  output logic [PW-1:0]        p,
  output logic [PW-1:0]        pcout,
  output logic [AW+BW-1:0]     m,
  output logic                 carryout,
  output logic                 overflow,
  output logic                 pattern_det
);

  localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");

  logic                 v1_q, cy1_q;
  logic [CHW-1:0]       ch1_q;
  logic signed [AW-1:0] a1_q, d1_q;
  logic signed [BW-1:0] b1_q;
  logic signed [CW-1:0] c1_q;
  logic [7:0]           op1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      cy1_q <= 1'b0;
      ch1_q <= '0;
      a1_q  <= '0;
      b1_q  <= '0;
      d1_q  <= '0;
      c1_q  <= '0;
      op1_q <= '0;
    end else if (ce) begin
      v1_q  <= in_valid;
      cy1_q <= carryin;
      ch1_q <= ch;
      a1_q  <= a;
      b1_q  <= b;
      d1_q  <= d;
      c1_q  <= c;
      op1_q <= opmode;
    end
  end

  logic signed [BW-1:0]    pre_d;
  logic signed [AW+BW-1:0] m_d;
  logic                    cin_d;

  always_comb begin
    pre_d = b1_q;
    if (op1_q[4]) pre_d = op1_q[6] ? (BW'(d1_q) - b1_q) : (BW'(d1_q) + b1_q);
  end

  assign m_d   = (AW+BW)'(a1_q) * (AW+BW)'(pre_d);
  assign cin_d = CIN_EXT ? cy1_q : op1_q[5];

  logic                    v2_q, cin2_q, sub2_q;
  logic [CHW-1:0]          ch2_q;
  logic signed [AW-1:0]    a2_q, d2_q;
  logic signed [BW-1:0]    b2_q;
  logic signed [CW-1:0]    c2_q;
  logic [1:0]              xsel2_q, zsel2_q;
  logic signed [AW+BW-1:0] m_q;

  // Datapath registers only load for valid samples so m keeps the last real product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      cin2_q  <= 1'b0;
      sub2_q  <= 1'b0;
      ch2_q   <= '0;
      a2_q    <= '0;
      b2_q    <= '0;
      d2_q    <= '0;
      c2_q    <= '0;
      xsel2_q <= '0;
      zsel2_q <= '0;
      m_q     <= '0;
    end else if (ce) begin
      v2_q <= v1_q;
      if (v1_q) begin
        cin2_q  <= cin_d;
        sub2_q  <= op1_q[7];
        ch2_q   <= ch1_q;
        a2_q    <= a1_q;
        b2_q    <= b1_q;
        d2_q    <= d1_q;
        c2_q    <= c1_q;
        xsel2_q <= op1_q[1:0];
        zsel2_q <= op1_q[3:2];
        m_q     <= m_d;
      end
    end
  end

  logic [PW-1:0]        acc_q [NCH];
  logic [PW-1:0]        acc_rd;
  logic signed [PW-1:0] x_d, z_d;
  logic signed [PW+1:0] t_d;
  logic [PW-1:0]        res_d;
  logic                 ovf_d, carry_d, pd_d;

  // Out-of-range channels match no entry and read as zero.
  always_comb begin
    acc_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch2_q == CHW'(i)) acc_rd = acc_q[i];
    end
  end

  always_comb begin
    x_d = '0;
    case (xsel2_q)
      2'b01:   x_d = PW'(m_q);
      2'b10:   x_d = acc_rd;
      2'b11:   x_d = PW'({d2_q, a2_q, b2_q});
      default: x_d = '0;
    endcase
    z_d = '0;
    case (zsel2_q)
      2'b01:   z_d = pcin;
      2'b10:   z_d = acc_rd;
      2'b11:   z_d = PW'(c2_q);
      default: z_d = '0;
    endcase
  end

  assign t_d = sub2_q
    ? ((PW+2)'(z_d) - ((PW+2)'(x_d) + $signed({{(PW+1){1'b0}}, cin2_q})))
    : ((PW+2)'(z_d) + (PW+2)'(x_d) + $signed({{(PW+1){1'b0}}, cin2_q}));

  // The unsigned PW+1 bit sum differs from the signed one only by the operand sign weights.
  assign carry_d = t_d[PW] ^ z_d[PW-1] ^ x_d[PW-1];
  assign ovf_d   = !((t_d[PW+1] == t_d[PW]) && (t_d[PW] == t_d[PW-1]));

  always_comb begin
    res_d = t_d[PW-1:0];
    if (SATURATE && ovf_d) res_d = t_d[PW+1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  assign pd_d = (((res_d ^ PATTERN) & ~MASK) == '0);

  logic                 out_valid_q, carry_q, ovf_q, pd_q;
  logic [CHW-1:0]       ch_out_q;
  logic [PW-1:0]        p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      pd_q        <= 1'b0;
      ch_out_q    <= '0;
      p_q         <= '0;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
    end else if (ce) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
        pd_q     <= pd_d;
        ch_out_q <= ch2_q;
        p_q      <= res_d;
        for (int i = 0; i < NCH; i++) begin
          if (ch2_q == CHW'(i)) acc_q[i] <= res_d;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign ch_out      = ch_out_q;
  assign p           = p_q;
  assign pcout       = p_q;
  assign m           = m_q;
  assign carryout    = carry_q;
  assign overflow    = ovf_q;
  assign pattern_det = pd_q;

endmodule

// File: tb/tb_dsp_mac_slice_mc.sv
// Bench for dsp_mac_slice_mc: wrapping and saturating instances driven in parallel,
// checked every cycle against an arithmetic model of the slice.
module tb_dsp_mac_slice_mc;

  localparam longint MAXP = 64'sd140737488355327;
  localparam longint MINN = -64'sd140737488355328;

  logic        clk = 1'b0;
  logic        rst_n, ce, in_valid, carryin;
  logic [1:0]  ch;
  logic [17:0] a, b, d;
  logic [47:0] c, pcin;
  logic [7:0]  opmode;

  logic        ov0, co0, of0, pd0, ov1, co1, of1, pd1;
  logic [1:0]  ch0o, ch1o;
  logic [47:0] p0, pc0, p1, pc1;
  logic [35:0] m0, m1;

  always #5 clk = ~clk;

  dsp_mac_slice_mc #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .ch(ch), .a(a), .b(b), .d(d),
    .c(c), .carryin(carryin), .opmode(opmode), .pcin(pcin), .out_valid(ov0), .ch_out(ch0o),
    .p(p0), .pcout(pc0), .m(m0), .carryout(co0), .overflow(of0), .pattern_det(pd0));

  dsp_mac_slice_mc #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .ch(ch), .a(a), .b(b), .d(d),
    .c(c), .carryin(carryin), .opmode(opmode), .pcin(pcin), .out_valid(ov1), .ch_out(ch1o),
    .p(p1), .pcout(pc1), .m(m1), .carryout(co1), .overflow(of1), .pattern_det(pd1));

  typedef struct {
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic [7:0]  op;
    logic [1:0]  ch;
    longint      due;
  } samp_t;

  typedef struct {
    logic [47:0] p;
    bit          co, ov, pd;
    longint      acc;
  } res_t;

  samp_t       q[$];
  longint      macc0 [4];
  longint      macc1 [4];
  logic [47:0] lastp0 [4];
  logic [47:0] lastp1 [4];
  longint      ce_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        e_ov;
  logic [1:0]  e_ch;
  logic [35:0] e_m;
  logic [47:0] e_p0, e_p1;
  logic        e_co0, e_of0, e_pd0, e_co1, e_of1, e_pd1;

  function automatic longint sx(input logic [63:0] v, input int n);
    longint r;
    r = longint'(v & ((64'd1 << n) - 64'd1));
    if (r[n-1]) r = r - (longint'(1) << n);
    return r;
  endfunction

  function automatic longint mprod(input samp_t s);
    longint opv;
    opv = sx(s.b, 18);
    if (s.op[4]) opv = s.op[6] ? sx(s.d, 18) - sx(s.b, 18) : sx(s.d, 18) + sx(s.b, 18);
    opv = sx(opv, 18);
    return sx(s.a, 18) * opv;
  endfunction

  function automatic res_t model(input samp_t s, input longint accv, input bit sat, input logic [47:0] pc);
    res_t        r;
    longint      xv, zv, tv, fin, zu, xu, cu, cin, msk;
    logic [53:0] dab;
    dab = {s.d, s.a, s.b};
    case (s.op[1:0])
      2'd0: xv = 0;
      2'd1: xv = mprod(s);
      2'd2: xv = accv;
      default: xv = sx(dab[47:0], 48);
    endcase
    case (s.op[3:2])
      2'd0: zv = 0;
      2'd1: zv = sx(pc, 48);
      2'd2: zv = accv;
      default: zv = sx(s.c, 48);
    endcase
    cin = s.op[5] ? 1 : 0;
    tv = s.op[7] ? zv - (xv + cin) : zv + xv + cin;
    r.ov = (tv > MAXP) || (tv < MINN);
    fin = (sat && r.ov) ? ((tv < 0) ? MINN : MAXP) : sx(tv, 48);
    r.p = 48'(fin);
    r.acc = fin;
    msk = (longint'(1) << 48) - 1;
    zu = zv & msk;
    xu = xv & msk;
    cu = s.op[7] ? zu - (xu + cin) : zu + xu + cin;
    r.co = cu[48];
    r.pd = (r.p == 48'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(ov0), 64'(e_ov));
    chk("out_valid_sat", 64'(ov1), 64'(e_ov));
    chk("ch_out", 64'(ch0o), 64'(e_ch));
    chk("ch_out_sat", 64'(ch1o), 64'(e_ch));
    chk("m", 64'(m0), 64'(e_m));
    chk("m_sat", 64'(m1), 64'(e_m));
    chk("p", 64'(p0), 64'(e_p0));
    chk("pcout", 64'(pc0), 64'(e_p0));
    chk("carryout", 64'(co0), 64'(e_co0));
    chk("overflow", 64'(of0), 64'(e_of0));
    chk("pattern_det", 64'(pd0), 64'(e_pd0));
    chk("p_sat", 64'(p1), 64'(e_p1));
    chk("pcout_sat", 64'(pc1), 64'(e_p1));
    chk("carryout_sat", 64'(co1), 64'(e_co1));
    chk("overflow_sat", 64'(of1), 64'(e_of1));
    chk("pattern_det_sat", 64'(pd1), 64'(e_pd1));
    if (ov0 === 1'b1 && ch0o !== 2'bxx) lastp0[ch0o] = p0;
    if (ov1 === 1'b1 && ch1o !== 2'bxx) lastp1[ch1o] = p1;
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      macc0[i] = 0;
      macc1[i] = 0;
      lastp0[i] = 'x;
      lastp1[i] = 'x;
    end
    e_ov = 0; e_ch = 0; e_m = 0;
    e_p0 = 0; e_co0 = 0; e_of0 = 0; e_pd0 = 0;
    e_p1 = 0; e_co1 = 0; e_of1 = 0; e_pd1 = 0;
  endtask

  task automatic tick();
    samp_t s;
    res_t  r0, r1;
    @(posedge clk);
    #1;
    if (ce && rst_n) begin
      ce_cnt++;
      foreach (q[i]) if (q[i].due == ce_cnt + 1) e_m = 36'(mprod(q[i]));
      e_ov = 0;
      if (q.size() > 0 && q[0].due == ce_cnt) begin
        s  = q.pop_front();
        r0 = model(s, macc0[s.ch], 1'b0, pcin);
        r1 = model(s, macc1[s.ch], 1'b1, pcin);
        macc0[s.ch] = r0.acc;
        macc1[s.ch] = r1.acc;
        e_ov = 1; e_ch = s.ch;
        e_p0 = r0.p; e_co0 = r0.co; e_of0 = r0.ov; e_pd0 = r0.pd;
        e_p1 = r1.p; e_co1 = r1.co; e_of1 = r1.ov; e_pd1 = r1.pd;
      end
      if (in_valid) begin
        s.a = a; s.b = b; s.d = d; s.c = c; s.op = opmode; s.ch = ch; s.due = ce_cnt + 2;
        q.push_back(s);
      end
    end
    check_all();
  endtask

  task automatic drv(input logic v, input logic [1:0] chv, input logic [17:0] av, input logic [17:0] bv,
                     input logic [17:0] dv, input logic [47:0] cv, input logic [7:0] op);
    in_valid = v; ch = chv; a = av; b = bv; d = dv; c = cv; opmode = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clear_model();
    check_all();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; ce = 1'b1; carryin = 1'b0; pcin = '0;
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    clear_model();
    do_reset();

    // latency: valid enters on edge 1, result visible after edge 3
    drv(1'b1, 2'd0, 18'd3, 18'd4, 18'd0, 48'd0, 8'h01);
    tick();
    drv(1'b0, 2'd0, 18'd3, 18'd4, 18'd0, 48'd0, 8'h01);
    tick();
    tick();
    chk("lat_valid", 64'(ov0), 64'd1);
    chk("lat_p", 64'(p0), 64'd12);
    chk("lat_m", 64'(m0), 64'd12);
    tick();

    // interleaved per-channel accumulation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 2'(i % 2), 18'((i % 2) + 1), 18'd2, 18'd0, 48'd0, 8'h09);
      tick();
    end
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    repeat (3) tick();
    chk("acc_ch0", 64'(lastp0[0]), 64'd8);
    chk("acc_ch1", 64'(lastp0[1]), 64'd16);

    // pre-adder subtract, then post-adder subtract from c
    drv(1'b1, 2'd0, 18'd5, 18'd3, 18'd10, 48'd0, 8'h51);
    tick();
    drv(1'b1, 2'd0, 18'd5, 18'd3, 18'd10, 48'd100, 8'hDD);
    tick();
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    tick();
    chk("preadd_sub", 64'(p0), 64'd35);
    tick();
    chk("postadd_sub", 64'(p0), 64'd65);

    // positive overflow: wrap vs clamp
    drv(1'b1, 2'd0, 18'd0, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 8'h0C);
    tick();
    drv(1'b1, 2'd0, 18'd1, 18'd1, 18'd0, 48'd0, 8'h09);
    tick();
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    tick();
    tick();
    chk("wrap_p", 64'(p0), 64'h8000_0000_0000);
    chk("wrap_ovf", 64'(of0), 64'd1);
    chk("sat_p", 64'(p1), 64'h7FFF_FFFF_FFFF);
    chk("sat_ovf", 64'(of1), 64'd1);

    // zero result raises pattern_det
    drv(1'b1, 2'd2, 18'd7, 18'd9, 18'd0, 48'd0, 8'h00);
    tick();
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    repeat (2) tick();
    chk("pattern_p", 64'(p0), 64'd0);
    chk("pattern_det_zero", 64'(pd0), 64'd1);

    // randomized stream with sporadic and one 5-cycle stall
    for (int i = 0; i < 240; i++) begin
      ce = ($urandom_range(0, 7) != 0);
      if (i >= 120 && i < 125) ce = 1'b0;
      carryin = 1'($urandom);
      pcin = 48'({$urandom(), $urandom()});
      drv(($urandom_range(0, 3) != 0), 2'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
          48'({$urandom(), $urandom()}),
          {4'($urandom), 2'($urandom), 2'($urandom_range(0, 2))});
      tick();
    end
    ce = 1'b1;
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    repeat (4) tick();

    // async reset with samples in flight
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 2'(i), 18'd11, 18'd13, 18'd0, 48'd0, 8'h09);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_p", 64'(p0), 64'd0);
    check_all();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 2'(i), '0, '0, '0, '0, 8'h08);
      tick();
    end
    drv(1'b0, 2'd0, '0, '0, '0, '0, 8'h00);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk("acc_after_rst", 64'(lastp0[i]), 64'd0);
      chk("acc_after_rst_sat", 64'(lastp1[i]), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
